// File: rtl/common.sv
// Shared types and limits for the data-memory port arbiter.
package common;

    typedef enum logic {
        ARB_CPU,
        ARB_HOST_RESP
    } arb_state_t;

    localparam int DM_STARVE_LIM_MAX = 255;

endpackage

// File: rtl/dm_starve_cnt.sv
// Saturating count of consecutive cycles a pending host request was denied.
module dm_starve_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic [7:0] lim_i,
    output logic       at_lim_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q < lim_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_lim_o = (cnt_q == lim_i);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a host
// loader; the CPU has priority, a starvation limit guarantees the host a slot.
module dm_port_arbiter
    import common::*;
#(
    parameter int DM_AW      = 12,
    parameter int STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re_i,
    input  logic             cpu_we_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic [31:0]      cpu_rdata_o,
    output logic             stall_o,
    input  logic             host_req_i,
    input  logic             host_we_i,
    input  logic [31:0]      host_addr_i,
    input  logic [31:0]      host_wdata_i,
    output logic             host_ack_o,
    output logic [31:0]      host_rdata_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [DM_AW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    arb_state_t state_q;
    logic       host_we_q;
    logic       cpu_req;
    logic       host_grant;
    logic       at_lim;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       unused_addr;

    assign cpu_req    = cpu_re_i | cpu_we_i;
    assign host_grant = host_req_i & (state_q == ARB_CPU)
                      & (~cpu_req | at_lim);
    assign cnt_inc    = host_req_i & (state_q == ARB_CPU) & ~host_grant;
    assign cnt_clr    = host_grant | ~host_req_i;

    dm_starve_cnt u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (cnt_inc),
        .clr_i    (cnt_clr),
        .lim_i    (LIM),
        .at_lim_o (at_lim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_CPU;
            host_we_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_CPU: begin
                    if (host_grant) begin
                        state_q   <= ARB_HOST_RESP;
                        host_we_q <= host_we_i;
                    end
                end
                ARB_HOST_RESP: state_q <= ARB_CPU;
                default:       state_q <= ARB_CPU;
            endcase
        end
    end

    // Store wins when the CPU raises both load and store.
    always_comb begin
        if (host_grant) begin
            mem_en_o    = 1'b1;
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i[DM_AW+1:2];
            mem_wdata_o = host_wdata_i;
        end else begin
            mem_en_o    = cpu_req;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i[DM_AW+1:2];
            mem_wdata_o = cpu_wdata_i;
        end
    end

    assign stall_o      = host_grant & cpu_req;
    assign cpu_rdata_o  = mem_rdata_i;
    assign host_ack_o   = (state_q == ARB_HOST_RESP);
    assign host_rdata_o = (host_ack_o && !host_we_q) ? mem_rdata_i : 32'h0;

    assign unused_addr = ^{cpu_addr_i[31:DM_AW+2], cpu_addr_i[1:0],
                           host_addr_i[31:DM_AW+2], host_addr_i[1:0]};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a 1-cycle-latency memory model.
module tb_dm_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        host_ack;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:4095];

    int n_chk;
    int n_fail;

    dm_port_arbiter #(.DM_AW(12), .STARVE_LIM(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_re_i     (cpu_re),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_rdata_o  (cpu_rdata),
        .stall_o      (stall),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_ack_o   (host_ack),
        .host_rdata_o (host_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous single-port memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 4096; i++)
            mem[i] = 32'h0;
        mem[4] = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        rst = 1'b1;
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;

        cyc();
        cyc();
        #1;
        check("rst_ack", {31'b0, host_ack}, 32'd0);
        check("rst_hrdata", host_rdata, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        rst = 1'b0;

        // CPU-only load
        cyc();
        cpu_re = 1; cpu_addr = 32'h10;
        #1;
        check("cpu_addr", {20'b0, mem_addr}, 32'd4);
        check("cpu_en", {31'b0, mem_en}, 32'd1);
        check("cpu_stall", {31'b0, stall}, 32'd0);
        cyc();
        cpu_re = 0;
        #1;
        check("cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("idle_en", {31'b0, mem_en}, 32'd0);

        // Host write then read
        cyc();
        host_req = 1; host_we = 1; host_addr = 32'h40;
        host_wdata = 32'h1234_5678;
        #1;
        check("hw_en", {31'b0, mem_en}, 32'd1);
        check("hw_we", {31'b0, mem_we}, 32'd1);
        check("hw_addr", {20'b0, mem_addr}, 32'd16);
        check("hw_wdata", mem_wdata, 32'h1234_5678);
        check("hw_noack", {31'b0, host_ack}, 32'd0);
        cyc();
        host_we = 0;
        #1;
        check("hw_ack", {31'b0, host_ack}, 32'd1);
        check("hw_rdata0", host_rdata, 32'h0);
        check("hw_no_reissue", {31'b0, mem_en}, 32'd0);
        cyc();
        #1;
        check("hr_en", {31'b0, mem_en}, 32'd1);
        check("hr_we", {31'b0, mem_we}, 32'd0);
        check("hr_noack", {31'b0, host_ack}, 32'd0);
        cyc();
        host_req = 0;
        #1;
        check("hr_ack", {31'b0, host_ack}, 32'd1);
        check("hr_rdata", host_rdata, 32'h1234_5678);

        // Starvation: CPU busy every cycle while host waits
        cyc();
        cpu_re = 1; cpu_addr = 32'h10;
        host_req = 1; host_we = 0; host_addr = 32'h40;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("st_deny_stall", {31'b0, stall}, 32'd0);
            check("st_deny_addr", {20'b0, mem_addr}, 32'd4);
            check("st_deny_ack", {31'b0, host_ack}, 32'd0);
            cyc();
            #1;
        end
        check("st_grant_stall", {31'b0, stall}, 32'd1);
        check("st_grant_addr", {20'b0, mem_addr}, 32'd16);
        // Ack cycle overlaps a fresh CPU load issue
        cyc();
        host_req = 0;
        #1;
        check("st_ack", {31'b0, host_ack}, 32'd1);
        check("st_ack_stall", {31'b0, stall}, 32'd0);
        check("st_ack_rdata", host_rdata, 32'h1234_5678);
        check("ov_cpu_en", {31'b0, mem_en}, 32'd1);
        check("ov_cpu_addr", {20'b0, mem_addr}, 32'd4);
        cyc();
        cpu_re = 0;
        #1;
        check("ov_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Contention below limit: CPU store wins
        cyc();
        cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'hAAAA_5555;
        host_req = 1; host_we = 0; host_addr = 32'h80;
        #1;
        check("ct_stall", {31'b0, stall}, 32'd0);
        check("ct_we", {31'b0, mem_we}, 32'd1);
        check("ct_addr", {20'b0, mem_addr}, 32'd32);
        check("ct_wdata", mem_wdata, 32'hAAAA_5555);
        check("ct_noack", {31'b0, host_ack}, 32'd0);
        cyc();
        cpu_we = 0;
        #1;
        check("ct_hgrant_en", {31'b0, mem_en}, 32'd1);
        check("ct_hgrant_we", {31'b0, mem_we}, 32'd0);
        check("ct_noack2", {31'b0, host_ack}, 32'd0);
        cyc();
        host_req = 0;
        #1;
        check("ct_ack", {31'b0, host_ack}, 32'd1);
        check("ct_rdata", host_rdata, 32'hAAAA_5555);

        // Reset during ARB_HOST_RESP
        cyc();
        host_req = 1; host_we = 0; host_addr = 32'h40;
        #1;
        check("rm_grant", {31'b0, mem_en}, 32'd1);
        cyc();
        rst = 1;
        #1;
        check("rm_ack_drop", {31'b0, host_ack}, 32'd0);
        check("rm_rdata0", host_rdata, 32'h0);
        cyc();
        rst = 0;
        #1;
        check("rm_regrant_en", {31'b0, mem_en}, 32'd1);
        check("rm_regrant_addr", {20'b0, mem_addr}, 32'd16);
        check("rm_regrant_ack", {31'b0, host_ack}, 32'd0);
        cyc();
        host_req = 0;
        #1;
        check("rm_ack", {31'b0, host_ack}, 32'd1);
        check("rm_rdata", host_rdata, 32'h1234_5678);
        cyc();
        #1;
        check("end_idle_ack", {31'b0, host_ack}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single-port synchronous data memory between the CPU MEM stage and an external host/debug loader. The CPU has priority, and a starvation limit guarantees the host a slot. When the host takes the port from a requesting CPU, the arbiter stalls the pipeline, freezing the MEM stage and the DM→WB register. It also routes the 1-cycle-latency read data back to whichever requester issued the access.

## Interface
Parameters:
- DM_AW, 12: data memory word-address width; mem_addr_o = addr[DM_AW+1:2].
- STARVE_LIM, 4: maximum consecutive cycles a pending host request may be denied. Legal range is 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_re_i  in  1  CPU MEM-stage load.
- cpu_we_i  in  1  CPU MEM-stage store.
- cpu_addr_i  in  32  CPU byte address, word aligned.
- cpu_wdata_i  in  32  CPU store data.
- cpu_rdata_o  out  32  load data, valid the cycle after an un-stalled CPU read issue.
- stall_o  out  1  CPU access denied this cycle; the pipeline holds.
- host_req_i  in  1  host request; held high until host_ack_o.
- host_we_i  in  1  host write (1) or read (0).
- host_addr_i  in  32  host byte address, word aligned.
- host_wdata_i  in  32  host write data.
- host_ack_o  out  1  host access complete; high for 1 cycle.
- host_rdata_o  out  32  read data qualified by host_ack_o; 0 otherwise.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  DM_AW  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, 1 cycle after issue.

## Operation
- **FSM** (state arb_state_t):
  - ARB_CPU: issue cycle.
  - ARB_HOST_RESP: the cycle after a host issue.
- **cpu_req** = cpu_re_i | cpu_we_i. If both are high, the access is treated as a write.
- **host_grant** (combinational) = host_req_i & (state == ARB_CPU) & (!cpu_req | starve_cnt == STARVE_LIM).
- **Memory port mux:**
  - When host_grant is high, the host drives the memory port.
  - Otherwise the CPU drives it with mem_en_o = cpu_req.
- **stall_o** = host_grant & cpu_req.
- **Transitions:**
  - ARB_CPU → ARB_HOST_RESP on host_grant.
  - ARB_HOST_RESP → ARB_CPU unconditionally.
- **In ARB_HOST_RESP:**
  - host_ack_o = 1.
  - host_rdata_o = mem_rdata_i for reads; 0 for writes.
  - The CPU may issue in the same cycle; memory is pipelined, so stall_o = 0.
  - A host_req_i still high in this cycle is ignored, so no double issue. Host peak throughput is therefore 1 access per 2 cycles.
- **cpu_rdata_o** = mem_rdata_i, passed through. The downstream DM→WB register captures it.
- **starve_cnt** (8-bit, saturating at STARVE_LIM):
  - Increments each cycle host_req_i is high and host_grant is low while in ARB_CPU.
  - Clears on host_grant and when host_req_i is low.

## Timing
- Reset values: state = ARB_CPU, starve_cnt = 0, host_ack_o = 0, host_rdata_o = 0, stall_o = 0.
- mem_* outputs are combinational from CPU inputs after reset; with no requests, mem_en_o = 0.
- Latency:
  - CPU read: issue in cycle N, data on cpu_rdata_o in N+1.
  - Host access: grant in N, host_ack_o in N+1.
- Worst-case host wait: STARVE_LIM cycles of denial, then a grant on the next evaluation. Grant occurs no later than STARVE_LIM+1 cycles after host_req_i rises.
- Worst-case CPU stall: 1 cycle per host grant. Consecutive host grants are at least 2 cycles apart.
- Simultaneous CPU and host requests with starve_cnt < STARVE_LIM: the CPU wins and starve_cnt increments.
- Reset asserted mid-operation: an in-flight host access is dropped with no ack. The host must keep or re-assert host_req_i and is re-arbitrated after reset deasserts.
- host_req_i dropped before ack is illegal. The arbiter still completes the ack for an already-granted access.

## Structure
- Shared package common holds:
  - arb_state_t {ARB_CPU, ARB_HOST_RESP}.
  - DM_STARVE_LIM_MAX = 255.
- Sub-module dm_starve_cnt: a saturating counter with inputs inc, clr, lim and output at_lim. It is instantiated once.
- The top holds the FSM, grant logic and port mux. It contains no other storage.

## Test plan
- **CPU only:** load from 0x0000_0010 with mem word[4] = 0xDEAD_BEEF → mem_addr_o = 4, mem_en_o = 1, stall_o = 0; cpu_rdata_o = 0xDEADBEEF the next cycle.
- **Host only:** write of 0x1234_5678 to 0x40, then a read of 0x40 → first ack 1 cycle after grant; second grant no earlier than 2 cycles after the first; read ack carries host_rdata_o = 0x12345678.
- **Starvation (STARVE_LIM = 4):** CPU requests every cycle while the host requests → 4 denied cycles, host granted on the 5th cycle with stall_o = 1 for exactly that cycle, host_ack_o the next cycle with stall_o = 0.
- **Contention below limit:** CPU and host request in the same cycle with starve_cnt = 0 → CPU issues, starve_cnt = 1, host_ack_o = 0.
- **Back-to-back overlap:** CPU read issued during ARB_HOST_RESP → host_ack_o and CPU issue occur in the same cycle; both read data values are correct.
- **Reset mid-access:** rst pulsed during ARB_HOST_RESP → host_ack_o = 0 immediately, state = ARB_CPU, starve_cnt = 0; the host is re-granted 1 cycle after rst deasserts (CPU idle).
